// File: rtl/memory_cycle.sv
// RV32I memory stage: word-organised data memory with byte-lane loads/stores,
// alignment checking, and the MEM/WB pipeline register feeding writeback.
module memory_cycle #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic        ResultSrcM,
    input  logic [4:0]  RdM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] PCPlus4M,
    output logic        RegWriteW,
    output logic        ResultSrcW,
    output logic [4:0]  RdW,
    output logic [31:0] ALUResultW,
    output logic [31:0] ReadDataW,
    output logic [31:0] PCPlus4W,
    output logic        MisalignM
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] word_idx;
    logic [1:0]            lane;
    logic [31:0]           rd_word;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;
    logic [31:0]           load_data;
    logic                  size_misalign;
    logic                  load_misalign;
    logic                  store_en;
    logic [3:0]            byte_en;
    logic [31:0]           store_data;

    assign word_idx = ALUResultM[DEPTH_LOG2+1:2];
    assign lane     = ALUResultM[1:0];
    assign rd_word  = mem[word_idx];

    // Alignment rule applies to funct3[1:0] alone, so unused encodings 110/111 are checked too.
    assign size_misalign = ((funct3M[1:0] == 2'b01) && lane[0]) ||
                           ((funct3M[1:0] == 2'b10) && (lane != 2'b00));
    assign MisalignM     = (MemWriteM || ResultSrcM) && size_misalign;
    assign load_misalign = ResultSrcM && size_misalign;

    always_comb begin
        rd_byte = rd_word[7:0];
        case (lane)
            2'd0: rd_byte = rd_word[7:0];
            2'd1: rd_byte = rd_word[15:8];
            2'd2: rd_byte = rd_word[23:16];
            2'd3: rd_byte = rd_word[31:24];
            default: rd_byte = rd_word[7:0];
        endcase
    end

    assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_data = 32'd0;
        case (funct3M)
            3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
            3'b010:  load_data = rd_word;
            3'b100:  load_data = {24'd0, rd_byte};
            3'b101:  load_data = {16'd0, rd_half};
            default: load_data = 32'd0;
        endcase
    end

    assign store_en = MemWriteM && !MisalignM && !funct3M[2] && (funct3M[1:0] != 2'b11);

    always_comb begin
        byte_en    = 4'b0000;
        store_data = WriteDataM;
        case (funct3M[1:0])
            2'b00: begin
                byte_en    = 4'b0001 << lane;
                store_data = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                byte_en    = lane[1] ? 4'b1100 : 4'b0011;
                store_data = {2{WriteDataM[15:0]}};
            end
            2'b10: begin
                byte_en    = 4'b1111;
                store_data = WriteDataM;
            end
            default: begin
                byte_en    = 4'b0000;
                store_data = WriteDataM;
            end
        endcase
    end

    // Memory is not reset, but a store must not land on an edge while reset is held.
    always_ff @(posedge clk) begin
        if (rst && store_en) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][8*i +: 8] <= store_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 1'b0;
            RdW        <= 5'd0;
            ALUResultW <= 32'd0;
            ReadDataW  <= 32'd0;
            PCPlus4W   <= 32'd0;
        end else begin
            RegWriteW  <= RegWriteM && !load_misalign;
            ResultSrcW <= ResultSrcM;
            RdW        <= RdM;
            ALUResultW <= ALUResultM;
            ReadDataW  <= load_misalign ? 32'd0 : load_data;
            PCPlus4W   <= PCPlus4M;
        end
    end

endmodule
